fb_port_arbiter: RTL and testbench

FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

---
 rtl/fb_port_arbiter.sv | 124 ++++++++++++
 tb/tb_fb_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: two-port frame-buffer arbiter with round-robin bursts and a registered memory strobe.
// Define FB_ARB_FIXED_PRIO_EN to give requester 0 absolute priority instead.
module fb_port_arbiter #(
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 3,
  parameter int MAX_BURST = 4
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  localparam logic [3:0] MAXB = 4'(MAX_BURST);
  state_t state_q, state_d, other;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic rr_q, rr_d;
  logic sel, xfer, hold_req, oth_req, we_sel;
  logic en_q, we_q, rd1_q, tag1_q, rd2_q, tag2_q, rv0_q, rv1_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;

  assign sel      = state_q == OWN1;
  assign hold_req = sel ? req1 : req0;
  assign oth_req  = sel ? req0 : req1;
  assign xfer     = state_q != IDLE && hold_req;
  assign we_sel   = sel ? we1 : we0;
  assign other    = sel ? OWN0 : OWN1;
  assign cnt_inc  = cnt_q == MAXB ? cnt_q : cnt_q + 4'd1;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  // rr_q names the requester that wins the next contention seen from IDLE
  always_comb begin
    state_d = state_q;
`ifdef FB_ARB_FIXED_PRIO_EN
    if (state_q == IDLE)
      state_d = req0 ? OWN0 : req1 ? OWN1 : IDLE;
    else if (!hold_req)
      state_d = oth_req ? other : IDLE;
    else if (sel && req0)
      state_d = OWN0;
`else
    if (state_q == IDLE)
      state_d = (req0 && req1) ? (rr_q ? OWN1 : OWN0) : req0 ? OWN0 : req1 ? OWN1 : IDLE;
    else if (!hold_req)
      state_d = oth_req ? other : IDLE;
    else if (oth_req && cnt_inc == MAXB)
      state_d = other;
`endif
    cnt_d = state_d != state_q ? 4'd0 : xfer ? cnt_inc : cnt_q;
    rr_d  = state_q == OWN0 ? 1'b1 : state_q == OWN1 ? 1'b0 : rr_q;
  end

  always_comb begin
    gnt0 = state_q == OWN0;
    gnt1 = state_q == OWN1;
  end

  // read tags ride two stages so the return lines up with synchronous memory data
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd1_q   <= 1'b0;
      tag1_q  <= 1'b0;
      rd2_q   <= 1'b0;
      tag2_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      en_q    <= xfer;
      we_q    <= xfer && we_sel;
      addr_q  <= xfer ? (sel ? addr1 : addr0) : addr_q;
      wdata_q <= xfer ? (sel ? wdata1 : wdata0) : wdata_q;
      rd1_q   <= xfer && !we_sel;
      tag1_q  <= sel;
      rd2_q   <= rd1_q;
      tag2_q  <= tag1_q;
      rv0_q   <= rd2_q && !tag2_q;
      rv1_q   <= rd2_q && tag2_q;
      rdata_q <= mem_rdata;
    end
  end

  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rvalid0   = rv0_q;
  assign rvalid1   = rv1_q;
  assign rdata0    = rdata_q;
  assign rdata1    = rdata_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed stimulus against a transaction-level arbiter model with a per-cycle compare.
module tb_fb_port_arbiter;
  localparam int MAXB = 4;
  logic clk = 1'b0;
  logic resetn, req0, req1, we0, we1;
  logic [14:0] addr0, addr1, mem_addr;
  logic [2:0] wdata0, wdata1, rdata0, rdata1, mem_wdata;
  logic [2:0] mem_rdata = 3'd0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
  int checks = 0, errors = 0, n = 0, rv0_cnt = 0, rv1_cnt = 0;

  fb_port_arbiter dut (
    .CLOCK_50(clk), .resetn(resetn), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [2:0] mem [0:32767];
  bit mem_loaded = 0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 32768; i++) mem[i] <= 3'(i * 5 + 1);
      mem[15'h7CFF] <= 3'd6;
      mem_loaded <= 1;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  // model: owner -1/0/1, burst length, last holder, shadow memory and queue of pending returns
  typedef struct {int due; int who; int data;} rd_t;
  rd_t rq[$];
  logic [2:0] sh [0:32767];
  bit sh_loaded = 0;
  int own, cnt, last, nxt, c, a, d;
  bit x0, x1, w, hr, orq;
  bit e_en, e_we, e_rv0, e_rv1;
  int e_addr, e_wd, e_rd;
  always @(posedge clk) begin
    n++;
    if (!sh_loaded) begin
      for (int i = 0; i < 32768; i++) sh[i] = 3'(i * 5 + 1);
      sh[15'h7CFF] = 3'd6;
      sh_loaded = 1;
    end
    if (!resetn) begin
      own = -1; cnt = 0; last = 1;
      e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_rv0 = 0; e_rv1 = 0;
      rq.delete();
    end else begin
      x0 = own == 0 && req0;
      x1 = own == 1 && req1;
      e_rv0 = 0; e_rv1 = 0;
      if (rq.size() > 0 && rq[0].due == n) begin
        if (rq[0].who == 0) e_rv0 = 1; else e_rv1 = 1;
        e_rd = rq[0].data;
        void'(rq.pop_front());
      end
      e_en = x0 || x1;
      e_we = (x0 && we0) || (x1 && we1);
      if (e_en) begin
        a = x0 ? int'(addr0) : int'(addr1);
        d = x0 ? int'(wdata0) : int'(wdata1);
        w = x0 ? we0 : we1;
        e_addr = a; e_wd = d;
        if (w) sh[a] = 3'(d);
        else rq.push_back('{n + 2, x1 ? 1 : 0, int'(sh[a])});
      end
      c = e_en ? (cnt + 1 > MAXB ? MAXB : cnt + 1) : cnt;
      nxt = own;
      if (own == -1) begin
`ifdef FB_ARB_FIXED_PRIO_EN
        nxt = req0 ? 0 : req1 ? 1 : -1;
`else
        nxt = (req0 && req1) ? 1 - last : req0 ? 0 : req1 ? 1 : -1;
`endif
      end else begin
        hr  = own == 0 ? req0 : req1;
        orq = own == 0 ? req1 : req0;
        if (!hr) nxt = orq ? 1 - own : -1;
`ifdef FB_ARB_FIXED_PRIO_EN
        else if (own == 1 && req0) nxt = 0;
`else
        else if (orq && c == MAXB) nxt = 1 - own;
`endif
        last = own;
      end
      cnt = nxt != own ? 0 : c;
      own = nxt;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", nm, got, exp, n);
    end
  endtask

  always @(negedge clk) begin
    if (n > 0) begin
      chk("gnt0", int'(gnt0), int'(own == 0));
      chk("gnt1", int'(gnt1), int'(own == 1));
      chk("mem_en", int'(mem_en), int'(e_en));
      chk("mem_we", int'(mem_we), int'(e_we));
      chk("mem_addr", int'(mem_addr), e_addr);
      chk("mem_wdata", int'(mem_wdata), e_wd);
      chk("rvalid0", int'(rvalid0), int'(e_rv0));
      chk("rvalid1", int'(rvalid1), int'(e_rv1));
      if (e_rv0) chk("rdata0", int'(rdata0), e_rd);
      if (e_rv1) chk("rdata1", int'(rdata1), e_rd);
      if (rvalid0) rv0_cnt++;
      if (rvalid1) rv1_cnt++;
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  int b0, b1;
  initial begin
    resetn = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step(2);
    chk("rst_gnt", int'({gnt0, gnt1}), 0);
    chk("rst_mem", int'({mem_en, mem_we, mem_addr, mem_wdata}), 0);
    chk("rst_rv", int'({rvalid0, rvalid1}), 0);
    resetn = 1; req0 = 1; we0 = 1; addr0 = 15'h0005; wdata0 = 3'd3;
    step(1);
    chk("w_gnt0", int'(gnt0), 1);
    chk("w_en_early", int'(mem_en), 0);
    step(1);
    chk("w_xfer", int'({mem_en, mem_we, mem_addr, mem_wdata}), int'({2'b11, 15'h0005, 3'd3}));
    chk("w_model_addr", e_addr, 5);
    req0 = 0;
    step(1);
    req1 = 1; we1 = 0; addr1 = 15'h7CFF;
    step(1);
    chk("r_gnt1", int'(gnt1), 1);
    step(1);
    chk("r_xfer", int'({mem_en, mem_we}), 2);
    req1 = 0;
    step(1);
    chk("r_rv_early", int'(rvalid1), 0);
    step(1);
    chk("r_rv1", int'(rvalid1), 1);
    chk("r_rdata1", int'(rdata1), 6);
    chk("r_rv0", int'(rvalid0), 0);
    step(1);
    chk("r_rv_once", int'(rvalid1), 0);
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; addr0 = 15'd200; addr1 = 15'd300; wdata0 = 3'd1; wdata1 = 3'd2;
    for (int k = 0; k < 12; k++) begin
      step(1);
`ifdef FB_ARB_FIXED_PRIO_EN
      chk("burst_gnt1", int'(gnt1), 0);
`else
      chk("burst_gnt1", int'(gnt1), (k / 4) % 2);
`endif
    end
    req0 = 0; req1 = 0;
    step(2);
    b0 = rv0_cnt; b1 = rv1_cnt;
    req1 = 1; we1 = 0; addr1 = 15'd100;
    step(1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("stream_xfer", int'({mem_en, gnt1 | gnt0}), 3);
      addr1 = 15'(101 + i);
      if (i == 8) begin req0 = 1; we0 = 1; addr0 = 15'd400; wdata0 = 3'd5; end
    end
    chk("stream_gnt", int'({gnt0, gnt1}), 2);
    req1 = 0;
    step(1);
    req0 = 0;
    step(5);
    chk("stream_rv1", rv1_cnt - b1, 10);
    chk("stream_rv0", rv0_cnt - b0, 0);
    req1 = 1; we1 = 0; addr1 = 15'd50;
    step(3);
    resetn = 0; req1 = 0;
    step(1);
    chk("mrst_out", int'({gnt0, gnt1, mem_en, mem_we, mem_addr, mem_wdata, rvalid0, rvalid1}), 0);
    resetn = 1;
    step(1);
    chk("mrst_rv_a", int'({rvalid0, rvalid1}), 0);
    step(1);
    chk("mrst_rv_b", int'({rvalid0, rvalid1}), 0);
    req0 = 1; we0 = 1; addr0 = 15'd7; wdata0 = 3'd2;
    step(1);
    chk("mrst_gnt0", int'(gnt0), 1);
    step(1);
    chk("mrst_xfer", int'({mem_en, mem_addr}), int'({1'b1, 15'd7}));
    req0 = 0;
    step(2);
`ifdef FB_ARB_FIXED_PRIO_EN
    req1 = 1; we1 = 0; addr1 = 15'd60;
    step(1);
    chk("fp_gnt1", int'(gnt1), 1);
    step(2);
    req0 = 1; we0 = 1; addr0 = 15'd61;
    step(1);
    chk("fp_preempt", int'({gnt0, gnt1}), 2);
    step(3);
    chk("fp_hold0", int'({gnt0, gnt1}), 2);
    req0 = 0;
    step(1);
    chk("fp_back1", int'({gnt0, gnt1}), 1);
    req1 = 0;
    step(4);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
